tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 select-driven mux path. It takes one serialized sample stream plus a frame-sync marker, tracks the slot position (slot index = {S1,S0} of the transmitting mux), and reconstructs the four channel values into registered parallel outputs. A full frame is published atomically with a one-cycle `frame_valid` pulse. It sits directly downstream of the mux, on the receive side of any link or register stage between them.

## Interface
- `WIDTH`, 1, bit width of each sample/channel
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  sample strobe; `din`/`sync` are valid only when high
- `din`  input  WIDTH  serialized sample
- `sync`  input  1  marks the slot-0 sample of a frame; qualified by `en`
- `O0`..`O3`  output  WIDTH each  reconstructed channels, slot k -> `Ok`
- `frame_valid`  output  1  one-cycle pulse when `O0`..`O3` update
- `sel`  output  2  slot index expected for the next `en` sample
- `locked`  output  1  high while in LOCKED
- `sync_err`  output  1  one-cycle pulse on a framing violation

## Operation
- States: HUNT, LOCKED. Reset -> HUNT.
- Cycles with `en`=0 change nothing. `frame_valid` and `sync_err` are driven low on those cycles.
- HUNT:
  - `en`=1 with `sync`=0: sample discarded.
  - `en`=1 with `sync`=1: `din` stored in shadow slot 0, `sel` <- 1, go to LOCKED.
- LOCKED, `en`=1:
  - `sel` = 0..2: `din` stored in shadow slot `sel`, `sel` increments.
  - `sel` = 3: `O0`..`O2` <- shadow slots 0..2, `O3` <- `din`, `frame_valid` pulses, `sel` wraps to 0.
- LOCKED, `sync`=1 at `sel` != 0 (early sync):
  - `sync_err` pulses and the partial frame is discarded.
  - `O*` keep their values; `frame_valid` does not pulse.
  - `din` is stored as slot 0 and `sel` <- 1 (realign). The block stays in LOCKED.
- LOCKED, `sync`=0 at `sel` = 0 (missing sync): behaviour depends on the macro in Configuration.
- A complete frame updates all four outputs in the same edge. There are no partial updates.
- `locked` = (state == LOCKED).

## Timing
- Reset values: `O0`..`O3` = 0, `frame_valid` = 0, `sync_err` = 0, `sel` = 0, `locked` = 0. Shadow registers = 0. State = HUNT.
- `rst` has priority over `en` on the same edge. Asserting `rst` mid-frame discards the partial frame and leaves the outputs at their reset values.
- Latency: on the edge that samples slot 3, `O0`..`O3` and `frame_valid` become visible in the following cycle.
- With `en` held high, the minimum frame period is 4 cycles, giving one `frame_valid` per 4 cycles. Back-to-back frames need no idle cycles.
- `sync_err` is registered and asserts in the cycle after the offending sample.
- Every output is a register. There are no combinational paths from inputs to outputs.

## Configuration
- `TDM_SYNC_STRICT_EN` defined:
  - Missing sync at slot 0 in LOCKED pulses `sync_err` and drops the sample.
  - State -> HUNT, `sel` <- 0.
- `TDM_SYNC_STRICT_EN` undefined (flywheel):
  - The slot-0 sample is accepted without `sync`.
  - No error is raised and the block stays in LOCKED.
- Early-sync handling is the same in both builds.

## Structure
- Package `tdm_pkg` holds:
  - state enum {HUNT, LOCKED}
  - `NUM_SLOTS` = 4
  - slot index type (2 bits)
- Sub-module `tdm_slot_ctr` is the 2-bit wrapping slot counter. Its controls are load-to-1, increment, and clear. It drives `sel`.
- The top level contains the FSM, the shadow registers and the output registers.

## Test plan
- Reset, then 4 `en` samples with `sync` on the first, `din` = 1,0,1,1 (WIDTH=1) -> `frame_valid` pulses once; `O0..O3` = 1,0,1,1; `locked` = 1.
- In HUNT, 3 samples with no `sync`, then a synced frame A,B,C,D (WIDTH=4: 3,5,9,F) -> pre-sync samples ignored; outputs = 3,5,9,F after the 4th synced sample.
- Locked, `sync` asserted at `sel` = 2 -> `sync_err` pulse, no `frame_valid`, `O*` unchanged, `sel` = 1 next; the following 3 samples complete a frame.
- Locked, slot 0 sent without `sync`:
  - strict build -> `sync_err` pulses, `locked` = 0.
  - flywheel build -> frame completes normally.
- `rst` asserted after 2 samples of a frame -> all outputs 0, `locked` = 0; the next synced frame reconstructs correctly.
- `en` toggling 1,0,1,0 across a frame -> outputs identical to the contiguous case; `frame_valid` pulses once, 1 cycle after the 4th strobe.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_demux4 receive path.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial sample bus into the demux plus the reconstructed parallel frame out of it.
interface tdm_demux4_if #(
    parameter int WIDTH = 1
) ();
    import tdm_pkg::*;

    logic             en;
    logic [WIDTH-1:0] din;
    logic             sync;

    logic [WIDTH-1:0] O0;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [WIDTH-1:0] O3;
    logic             frame_valid;
    slot_t            sel;
    logic             locked;
    logic             sync_err;

    modport master (
        output en, din, sync,
        input  O0, O1, O2, O3, frame_valid, sel, locked, sync_err
    );

    modport slave (
        input  en, din, sync,
        output O0, O1, O2, O3, frame_valid, sel, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// 2-bit wrapping slot counter; clear beats load-to-1, which beats increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load1,
    input  logic  inc,
    output slot_t sel
);

    slot_t cnt_q;
    slot_t cnt_d;

    // next slot index
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (load1) begin
            cnt_d = 2'd1;
        end else if (inc) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // slot index register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sel = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: tracks the slot position of a serial stream
// and publishes each complete frame atomically on registered outputs.
// Build option: TDM_SYNC_STRICT_EN -- when defined, a missing sync at slot 0
// while locked is a framing error (drop to HUNT); otherwise the block flywheels.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | waiting for an en-qualified sync; all samples discarded
// LOCKED | slot position known; samples stored by sel, slot 3 publishes
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input logic         clk,
    input logic         rst,
    tdm_demux4_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic [WIDTH-1:0] o2_q, o2_d;
    logic [WIDTH-1:0] o3_q, o3_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    logic  ctr_clr;
    logic  ctr_load1;
    logic  ctr_inc;
    slot_t sel;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .sel   (sel)
    );

    // framing FSM, shadow capture and atomic frame publish
    always_comb begin
        state_d   = state_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        o0_d      = o0_q;
        o1_d      = o1_q;
        o2_d      = o2_q;
        o3_d      = o3_q;
        fv_d      = 1'b0;
        err_d     = 1'b0;
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;

        if (bus.en) begin
            case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        sh0_d     = bus.din;
                        ctr_load1 = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.sync && (sel != 2'd0)) begin
                        // early sync: abandon the partial frame and realign on this sample
                        err_d     = 1'b1;
                        sh0_d     = bus.din;
                        ctr_load1 = 1'b1;
                    end else if (!bus.sync && (sel == 2'd0)) begin
`ifdef TDM_SYNC_STRICT_EN
                        err_d   = 1'b1;
                        ctr_clr = 1'b1;
                        state_d = HUNT;
`else
                        sh0_d   = bus.din;
                        ctr_inc = 1'b1;
`endif
                    end else begin
                        ctr_inc = 1'b1;
                        case (sel)
                            2'd0: sh0_d = bus.din;
                            2'd1: sh1_d = bus.din;
                            2'd2: sh2_d = bus.din;
                            default: begin
                                o0_d = sh0_q;
                                o1_d = sh1_q;
                                o2_d = sh2_q;
                                o3_d = bus.din;
                                fv_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // state, shadow and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            o0_q    <= '0;
            o1_q    <= '0;
            o2_q    <= '0;
            o3_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            o0_q    <= o0_d;
            o1_q    <= o1_d;
            o2_q    <= o2_d;
            o3_q    <= o3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign bus.O0          = o0_q;
    assign bus.O1          = o1_q;
    assign bus.O2          = o2_q;
    assign bus.O3          = o3_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = err_q;
    assign bus.sel         = sel;
    assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scenario bench for tdm_demux4: expected frames are queued as stimulus is
// driven; frames seen on frame_valid are queued by a monitor and compared.
module tb_tdm_demux4;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [4*W-1:0] exp_q[$];
    logic [4*W-1:0] obs_q[$];
    int             err_cnt;
    int             assert_cnt;
    int             fail_cnt;

    // capture every published frame and count error pulses, mid-cycle
    always @(negedge clk) begin
        if (!rst && bus.frame_valid === 1'b1) obs_q.push_back({bus.O0, bus.O1, bus.O2, bus.O3});
        if (!rst && bus.sync_err === 1'b1) err_cnt++;
    end

    task automatic step(input logic e, input logic [W-1:0] d, input logic s);
        bus.en   = e;
        bus.din  = d;
        bus.sync = s;
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b1, 4'hA, 1'b1);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        err_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        assert_cnt++;
        if ({bus.O0, bus.O1, bus.O2, bus.O3} !== 16'h0000) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got %h want 0000", {bus.O0, bus.O1, bus.O2, bus.O3});
        end
        assert_cnt++;
        if ({bus.frame_valid, bus.sync_err, bus.locked} !== 3'b000) begin
            fail_cnt++;
            $display("FAIL reset_flags: got fv/err/locked=%b want 000", {bus.frame_valid, bus.sync_err, bus.locked});
        end
        assert_cnt++;
        if (bus.sel !== 2'd0) begin
            fail_cnt++;
            $display("FAIL reset_sel: got %0d want 0", bus.sel);
        end
    endtask

    task automatic test_basic();
        logic [4*W-1:0] e, o;
        step(1'b1, 4'h1, 1'b1);
        step(1'b1, 4'h0, 1'b0);
        step(1'b1, 4'h1, 1'b0);
        assert_cnt++;
        if (bus.frame_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL basic_fv_early: got %b want 0", bus.frame_valid);
        end
        step(1'b1, 4'h1, 1'b0);
        exp_q.push_back({4'h1, 4'h0, 4'h1, 4'h1});
        assert_cnt++;
        if (bus.frame_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL basic_fv_latency: got %b want 1", bus.frame_valid);
        end
        assert_cnt++;
        if ({bus.locked, bus.sel} !== 3'b100) begin
            fail_cnt++;
            $display("FAIL basic_locked_sel: got %b want 100", {bus.locked, bus.sel});
        end
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (bus.frame_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL basic_fv_one_cycle: got %b want 0", bus.frame_valid);
        end
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL basic_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL basic_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_hunt();
        logic [4*W-1:0] e, o;
        do_reset();
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        step(1'b1, 4'hE, 1'b0);
        assert_cnt++;
        if ({bus.locked, bus.sel} !== 3'b000) begin
            fail_cnt++;
            $display("FAIL hunt_ignored: got locked/sel=%b want 000", {bus.locked, bus.sel});
        end
        step(1'b1, 4'h3, 1'b1);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h9, 1'b0);
        step(1'b1, 4'hF, 1'b0);
        exp_q.push_back(16'h359F);
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL hunt_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL hunt_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_early_sync();
        logic [4*W-1:0] e, o;
        int             err0;
        err0 = err_cnt;
        step(1'b1, 4'hA, 1'b1);
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'hC, 1'b1);
        assert_cnt++;
        if ({bus.sync_err, bus.frame_valid, bus.sel} !== 4'b1001) begin
            fail_cnt++;
            $display("FAIL early_sync_flags: got err/fv/sel=%b want 1001", {bus.sync_err, bus.frame_valid, bus.sel});
        end
        assert_cnt++;
        if ({bus.O0, bus.O1, bus.O2, bus.O3} !== 16'h359F) begin
            fail_cnt++;
            $display("FAIL early_sync_hold: got %h want 359F", {bus.O0, bus.O1, bus.O2, bus.O3});
        end
        step(1'b1, 4'hD, 1'b0);
        step(1'b1, 4'hE, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        exp_q.push_back(16'hCDE2);
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (err_cnt - err0 !== 1) begin
            fail_cnt++;
            $display("FAIL early_sync_err_count: got %0d want 1", err_cnt - err0);
        end
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL early_sync_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL early_sync_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_missing_sync();
        logic [4*W-1:0] e, o;
        int             err0;
        err0 = err_cnt;
        step(1'b1, 4'h1, 1'b0);
`ifdef TDM_SYNC_STRICT_EN
        assert_cnt++;
        if ({bus.sync_err, bus.locked, bus.sel} !== 4'b1000) begin
            fail_cnt++;
            $display("FAIL strict_missing_sync: got err/locked/sel=%b want 1000", {bus.sync_err, bus.locked, bus.sel});
        end
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h4, 1'b0);
`else
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        exp_q.push_back(16'h1234);
        assert_cnt++;
        if ({bus.locked, bus.frame_valid} !== 2'b11) begin
            fail_cnt++;
            $display("FAIL flywheel_frame: got locked/fv=%b want 11", {bus.locked, bus.frame_valid});
        end
`endif
        step(1'b0, '0, 1'b0);
        assert_cnt++;
`ifdef TDM_SYNC_STRICT_EN
        if (err_cnt - err0 !== 1) begin
            fail_cnt++;
            $display("FAIL missing_sync_err_count: got %0d want 1", err_cnt - err0);
        end
`else
        if (err_cnt - err0 !== 0) begin
            fail_cnt++;
            $display("FAIL missing_sync_err_count: got %0d want 0", err_cnt - err0);
        end
`endif
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL missing_sync_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL missing_sync_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [4*W-1:0] e, o;
        step(1'b1, 4'hB, 1'b1);
        step(1'b1, 4'hC, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'hD, 1'b0);
        rst = 1'b0;
        obs_q.delete();
        assert_cnt++;
        if ({bus.O0, bus.O1, bus.O2, bus.O3, bus.locked, bus.sel, bus.frame_valid} !== 20'h0) begin
            fail_cnt++;
            $display("FAIL reset_mid_state: got O=%h locked=%b sel=%0d fv=%b want all 0",
                     {bus.O0, bus.O1, bus.O2, bus.O3}, bus.locked, bus.sel, bus.frame_valid);
        end
        step(1'b1, 4'h6, 1'b1);
        step(1'b1, 4'h7, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        step(1'b1, 4'h9, 1'b0);
        exp_q.push_back(16'h6789);
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL reset_mid_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL reset_mid_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_gapped();
        logic [4*W-1:0] e, o;
        step(1'b1, 4'h4, 1'b1);
        step(1'b0, 4'hF, 1'b1);
        assert_cnt++;
        if ({bus.sel, bus.sync_err} !== 3'b010) begin
            fail_cnt++;
            $display("FAIL gapped_idle_hold: got sel/err=%b want 010", {bus.sel, bus.sync_err});
        end
        step(1'b1, 4'hB, 1'b0);
        step(1'b0, 4'hF, 1'b0);
        step(1'b1, 4'h1, 1'b0);
        step(1'b0, 4'hF, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        exp_q.push_back(16'h4B18);
        assert_cnt++;
        if (bus.frame_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL gapped_fv_latency: got %b want 1", bus.frame_valid);
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL gapped_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL gapped_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [4*W-1:0] e, o;
        logic [W-1:0]   s[4];
        int             err0;
        err0 = err_cnt;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 4; k++) begin
                s[k] = W'($urandom_range(0, 15));
                step(1'b1, s[k], (k == 0));
            end
            exp_q.push_back({s[0], s[1], s[2], s[3]});
        end
        step(1'b0, '0, 1'b0);
        assert_cnt++;
        if (err_cnt - err0 !== 0) begin
            fail_cnt++;
            $display("FAIL b2b_no_err: got %0d errors want 0", err_cnt - err0);
        end
        assert_cnt++;
        if (obs_q.size() !== exp_q.size()) begin
            fail_cnt++;
            $display("FAIL b2b_frame_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            assert_cnt++;
            if (o !== e) begin
                fail_cnt++;
                $display("FAIL b2b_frame: got %h want %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        err_cnt    = 0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.din    = '0;
        bus.sync   = 1'b0;
        test_reset();
        test_basic();
        test_hunt();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        test_gapped();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
